// File: rtl/apb_demux_pkg.sv
// apb_demux shared types: FSM states, response bundle,
// and the index-width helper used by the decoder and the top.
package apb_demux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR
  } state_t;

  localparam int RESP_DW = 32;

  typedef struct packed {
    logic [RESP_DW-1:0] rdata;
    logic               slverr;
  } resp_t;

  // Never returns 0 so a single-entry field still has a legal width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_demux_if.sv
// APB splitter bus bundle: requester side (_s) and the
// broadcast / per-completer side (_m).
interface apb_demux_if #(
  parameter int NUM_APB_SLAVES = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_STRB_WIDTH = APB_DATA_WIDTH/8
);

  logic                      PSEL_s;
  logic                      PENABLE_s;
  logic                      PWRITE_s;
  logic [APB_ADDR_WIDTH-1:0] PADDR_s;
  logic [APB_DATA_WIDTH-1:0] PWDATA_s;
  logic [APB_STRB_WIDTH-1:0] PSTRB_s;
  logic [2:0]                PPROT_s;
  logic [APB_DATA_WIDTH-1:0] PRDATA_s;
  logic                      PREADY_s;
  logic                      PSLVERR_s;

  logic [NUM_APB_SLAVES-1:0] PSEL_m;
  logic                      PENABLE_m;
  logic                      PWRITE_m;
  logic [APB_ADDR_WIDTH-1:0] PADDR_m;
  logic [APB_DATA_WIDTH-1:0] PWDATA_m;
  logic [APB_STRB_WIDTH-1:0] PSTRB_m;
  logic [2:0]                PPROT_m;
  logic [NUM_APB_SLAVES-1:0]
        [APB_DATA_WIDTH-1:0] PRDATA_m;
  logic [NUM_APB_SLAVES-1:0] PREADY_m;
  logic [NUM_APB_SLAVES-1:0] PSLVERR_m;

  modport slave (
    input  PSEL_s, PENABLE_s, PWRITE_s,
    input  PADDR_s, PWDATA_s, PSTRB_s, PPROT_s,
    output PRDATA_s, PREADY_s, PSLVERR_s,
    output PSEL_m, PENABLE_m, PWRITE_m,
    output PADDR_m, PWDATA_m, PSTRB_m, PPROT_m,
    input  PRDATA_m, PREADY_m, PSLVERR_m
  );

  modport master (
    output PSEL_s, PENABLE_s, PWRITE_s,
    output PADDR_s, PWDATA_s, PSTRB_s, PPROT_s,
    input  PRDATA_s, PREADY_s, PSLVERR_s,
    input  PSEL_m, PENABLE_m, PWRITE_m,
    input  PADDR_m, PWDATA_m, PSTRB_m, PPROT_m,
    output PRDATA_m, PREADY_m, PSLVERR_m
  );

endinterface

// File: rtl/apb_demux_addr_decode.sv
// Address window decoder: tag bits above the index field must
// match BASE_ADDR, and the index must name an existing completer.
module apb_addr_decode
  import apb_demux_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int SLV_ADDR_WIDTH = 12,
  parameter int NUM_APB_SLAVES = 8,
  localparam int IDX_W = idx_w(NUM_APB_SLAVES)
) (
  input  logic [APB_ADDR_WIDTH-1:SLV_ADDR_WIDTH] addr,
  output logic                                   hit,
  output logic [IDX_W-1:0]                       idx
);

  localparam int TAG_LSB = SLV_ADDR_WIDTH + IDX_W;

  logic tag_ok;
  logic in_range;

  assign idx = addr[SLV_ADDR_WIDTH +: IDX_W];

  assign tag_ok =
    addr[APB_ADDR_WIDTH-1:TAG_LSB] ==
    BASE_ADDR[APB_ADDR_WIDTH-1:TAG_LSB];

  generate
    if (NUM_APB_SLAVES == (1 << IDX_W)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range =
        {1'b0, idx} < (IDX_W+1)'(NUM_APB_SLAVES);
    end
  endgenerate

  assign hit = tag_ok & in_range;

endmodule

// File: rtl/apb_demux.sv
// 1-to-N APB splitter with registered request/response paths,
// local error termination for unmapped and silent completers.
module apb_demux
  import apb_demux_pkg::*;
#(
  parameter int NUM_APB_SLAVES = 8,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_STRB_WIDTH = APB_DATA_WIDTH/8,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int SLV_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  apb_demux_if.slave  bus,
  output logic        timeout_o,
  output logic        unmapped_o
);

  localparam int IDX_W = idx_w(NUM_APB_SLAVES);
  localparam int CNT_W = idx_w(TIMEOUT_CYCLES);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int SW = APB_STRB_WIDTH;

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [NUM_APB_SLAVES-1:0] psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [AW-1:0]             paddr_q;
  logic [DW-1:0]             pwdata_q;
  logic [SW-1:0]             pstrb_q;
  logic [2:0]                pprot_q;
  resp_t                     resp_q;
  logic                      pready_q;
  logic                      pslverr_q;
  logic [DW-1:0]             prdata_q;
  logic                      timeout_q;
  logic                      unmapped_q;

  logic                      dec_hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      setup;
  logic                      sel_ready;
  logic                      expired;

  apb_addr_decode #(
    .APB_ADDR_WIDTH (AW),
    .BASE_ADDR      (BASE_ADDR),
    .SLV_ADDR_WIDTH (SLV_ADDR_WIDTH),
    .NUM_APB_SLAVES (NUM_APB_SLAVES)
  ) u_dec (
    .addr (bus.PADDR_s[AW-1:SLV_ADDR_WIDTH]),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign setup     = bus.PSEL_s & ~bus.PENABLE_s;
  assign sel_ready = bus.PREADY_m[idx_q];
  assign expired   = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

  // Completer response is checked before expiry so it wins a tie.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      pprot_q    <= '0;
      resp_q     <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      timeout_q  <= 1'b0;
      unmapped_q <= 1'b0;
    end else begin
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      timeout_q  <= 1'b0;
      unmapped_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (setup) begin
            idx_q    <= dec_idx;
            pwrite_q <= bus.PWRITE_s;
            paddr_q  <= bus.PADDR_s;
            pwdata_q <= bus.PWDATA_s;
            pstrb_q  <= bus.PSTRB_s;
            pprot_q  <= bus.PPROT_s;
            if (dec_hit) begin
              state_q <= SETUP;
              psel_q  <= NUM_APB_SLAVES'(1) << dec_idx;
            end else begin
              state_q    <= ERR;
              pready_q   <= 1'b1;
              pslverr_q  <= 1'b1;
              unmapped_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: begin
          if (sel_ready) begin
            state_q   <= RESP;
            psel_q    <= '0;
            penable_q <= 1'b0;
            resp_q    <= '{
              rdata:  RESP_DW'(bus.PRDATA_m[idx_q]),
              slverr: bus.PSLVERR_m[idx_q]
            };
          end else if (expired) begin
            state_q   <= RESP;
            psel_q    <= '0;
            penable_q <= 1'b0;
            resp_q    <= '{rdata: '0, slverr: 1'b1};
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b1;
          pslverr_q <= resp_q.slverr;
          prdata_q  <= DW'(resp_q.rdata);
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.PSEL_m    = psel_q;
  assign bus.PENABLE_m = penable_q;
  assign bus.PWRITE_m  = pwrite_q;
  assign bus.PADDR_m   = paddr_q;
  assign bus.PWDATA_m  = pwdata_q;
  assign bus.PSTRB_m   = pstrb_q;
  assign bus.PPROT_m   = pprot_q;
  assign bus.PRDATA_s  = prdata_q;
  assign bus.PREADY_s  = pready_q;
  assign bus.PSLVERR_s = pslverr_q;
  assign timeout_o     = timeout_q;
  assign unmapped_o    = unmapped_q;

endmodule

// File: tb/tb_apb_demux.sv
// Bench for apb_demux: vector table of transfers, completer model,
// response scoreboard, and hand-written reset-abort sequence.
module tb_apb_demux;
  import apb_demux_pkg::*;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_o;
  logic unmapped_o;

  always #5 clk = ~clk;

  apb_demux_if #(
    .NUM_APB_SLAVES (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .APB_STRB_WIDTH (SW)
  ) bus ();

  apb_demux #(
    .NUM_APB_SLAVES (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .APB_STRB_WIDTH (SW),
    .BASE_ADDR      (32'h4000_0000),
    .SLV_ADDR_WIDTH (12),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK       (clk),
    .PRESETn    (rst_n),
    .bus        (bus),
    .timeout_o  (timeout_o),
    .unmapped_o (unmapped_o)
  );

  typedef struct {
    string         name;
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            sidx;
    bit            hit;
    int            w;
    bit            hang;
    logic [DW-1:0] rdata;
    bit            err;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          slverr;
  } exp_t;

  int            waits [N];
  bit            hang  [N];
  logic [DW-1:0] rdat  [N];
  bit            serr  [N];
  int            acc   [N];

  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   tmo_cnt = 0;
  int   unm_cnt = 0;
  exp_t exp_q [$];
  vec_t vt [10];

  always @(posedge clk) cyc <= cyc + 1;

  // Completer model: ready once `waits` access cycles have elapsed.
  always_comb begin
    bus.PREADY_m  = '0;
    bus.PSLVERR_m = '0;
    bus.PRDATA_m  = '0;
    for (int s = 0; s < N; s++) begin
      bus.PRDATA_m[s] = rdat[s];
      if (bus.PSEL_m[s] && bus.PENABLE_m && !hang[s]
          && acc[s] >= waits[s]) begin
        bus.PREADY_m[s]  = 1'b1;
        bus.PSLVERR_m[s] = serr[s];
      end
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < N; s++) begin
      if (bus.PSEL_m[s] && bus.PENABLE_m && !bus.PREADY_m[s])
        acc[s] <= acc[s] + 1;
      else
        acc[s] <= 0;
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (timeout_o) tmo_cnt++;
      if (unmapped_o) unm_cnt++;
      if (bus.PREADY_s) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_rdata", bus.PRDATA_s, e.rdata);
          check("sb_slverr", bus.PSLVERR_s, e.slverr);
        end
      end
    end
  end

  function automatic vec_t mk(
    input string nm, input bit wr, input logic [AW-1:0] a,
    input logic [DW-1:0] wd, input logic [SW-1:0] st,
    input logic [2:0] pr, input int s, input bit h,
    input int w, input bit hg, input logic [DW-1:0] rd,
    input bit er);
    vec_t v;
    v.name = nm;  v.write = wr; v.addr = a;  v.wdata = wd;
    v.strb = st;  v.prot = pr;  v.sidx = s;  v.hit = h;
    v.w = w;      v.hang = hg;  v.rdata = rd; v.err = er;
    return v;
  endfunction

  task automatic set_model(input vec_t v);
    for (int s = 0; s < N; s++) begin
      hang[s]  = 1'b0;
      waits[s] = 0;
      rdat[s]  = 32'hBAD0_0000 + DW'(s);
      serr[s]  = 1'b0;
    end
    if (v.hit) begin
      hang[v.sidx]  = v.hang;
      waits[v.sidx] = v.w;
      rdat[v.sidx]  = v.rdata;
      serr[v.sidx]  = v.err;
    end
  endtask

  // Entered and left at #1 after a rising edge, so calls chain
  // back-to-back with the new setup right after PREADY_s.
  task automatic xfer(input vec_t v);
    exp_t          e;
    int            ew, exp_lat, lat, t0, tmo_at, sel_cyc;
    int            tmo0, unm0;
    bit            done;
    logic [N-1:0]  mask, other;
    set_model(v);
    mask = v.hit ? (N'(1) << v.sidx) : '0;
    ew = v.hang ? TO - 1 : v.w;
    exp_lat = v.hit ? 4 + ew : 1;
    e.rdata  = (v.hit && !v.hang) ? v.rdata : '0;
    e.slverr = !v.hit || v.hang || v.err;
    exp_q.push_back(e);
    tmo0 = tmo_cnt;
    unm0 = unm_cnt;
    bus.PSEL_s    = 1'b1;
    bus.PENABLE_s = 1'b0;
    bus.PWRITE_s  = v.write;
    bus.PADDR_s   = v.addr;
    bus.PWDATA_s  = v.wdata;
    bus.PSTRB_s   = v.strb;
    bus.PPROT_s   = v.prot;
    t0 = cyc;
    @(posedge clk); #1;
    bus.PENABLE_s = 1'b1;
    bus.PWDATA_s  = ~v.wdata;
    bus.PSTRB_s   = ~v.strb;
    done = 1'b0; lat = 0; tmo_at = -1; sel_cyc = 0; other = '0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if ((bus.PSEL_m & mask) != '0) sel_cyc++;
      other |= bus.PSEL_m & ~mask;
      if (timeout_o) tmo_at = cyc - t0;
      if (v.hit && cyc == t0 + 1)
        check({v.name, "_setup_en"}, bus.PENABLE_m, 1'b0);
      if (v.hit && cyc == t0 + 2) begin
        check({v.name, "_acc_en"}, bus.PENABLE_m, 1'b1);
        check({v.name, "_paddr"}, bus.PADDR_m, v.addr);
        check({v.name, "_pwrite"}, bus.PWRITE_m, v.write);
        check({v.name, "_pwdata"}, bus.PWDATA_m, v.wdata);
        check({v.name, "_pstrb"}, bus.PSTRB_m, v.strb);
        check({v.name, "_pprot"}, bus.PPROT_m, v.prot);
      end
      if (bus.PREADY_s) begin
        done = 1'b1;
        lat  = cyc - t0;
      end
    end
    check({v.name, "_latency"}, lat, exp_lat);
    check({v.name, "_psel_cycles"}, sel_cyc, v.hit ? 2 + ew : 0);
    check({v.name, "_other_psel"}, other, '0);
    if (v.hang)
      check({v.name, "_tmo_cycle"}, tmo_at, exp_lat - 1);
    @(posedge clk); #1;
    check({v.name, "_tmo_pulses"}, tmo_cnt - tmo0, v.hang ? 1 : 0);
    check({v.name, "_unm_pulses"}, unm_cnt - unm0, v.hit ? 0 : 1);
    check({v.name, "_sb_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = mk("wr_s3", 1, 32'h4000_3010, 32'hDEAD_BEEF, 4'hF, 3'd0,
               3, 1, 0, 0, 32'h0, 0);
    vt[1] = mk("rd_s5_w3", 0, 32'h4000_5004, 32'h0, 4'h0, 3'd2,
               5, 1, 3, 0, 32'h1234_5678, 0);
    vt[2] = mk("unm_idx9", 0, 32'h4000_9000, 32'h0, 4'h0, 3'd0,
               0, 0, 0, 0, 32'h0, 0);
    vt[3] = mk("unm_far", 0, 32'h5000_0000, 32'h0, 4'h0, 3'd0,
               0, 0, 0, 0, 32'h0, 0);
    vt[4] = mk("tmo_s2", 0, 32'h4000_2000, 32'h0, 4'h0, 3'd1,
               2, 1, 0, 1, 32'h0, 0);
    vt[5] = mk("edge_s2", 0, 32'h4000_2004, 32'h0, 4'h0, 3'd0,
               2, 1, TO - 1, 0, 32'hA5A5_5A5A, 0);
    vt[6] = mk("err_s1", 0, 32'h4000_1008, 32'h0, 4'h0, 3'd0,
               1, 1, 1, 0, 32'h0BAD_0001, 1);
    vt[7] = mk("b2b_s0", 1, 32'h4000_0000, 32'h0102_0304, 4'h3, 3'd4,
               0, 1, 0, 0, 32'h0, 0);
    vt[8] = mk("rd_s7", 0, 32'h4000_7FFC, 32'h0, 4'h0, 3'd7,
               7, 1, 2, 0, 32'h7777_8888, 0);
    vt[9] = mk("unm_below", 0, 32'h3FFF_F000, 32'h0, 4'h0, 3'd0,
               0, 0, 0, 0, 32'h0, 0);

    bus.PSEL_s = 0; bus.PENABLE_s = 0; bus.PWRITE_s = 0;
    bus.PADDR_s = '0; bus.PWDATA_s = '0; bus.PSTRB_s = '0;
    bus.PPROT_s = '0;
    set_model(vt[2]);
    rst_n = 1'b0;

    repeat (2) @(posedge clk); #1;
    check("rst_psel", bus.PSEL_m, '0);
    check("rst_penable", bus.PENABLE_m, 1'b0);
    check("rst_paddr", bus.PADDR_m, '0);
    check("rst_pwdata", bus.PWDATA_m, '0);
    check("rst_pready", bus.PREADY_s, 1'b0);
    check("rst_pslverr", bus.PSLVERR_s, 1'b0);
    check("rst_prdata", bus.PRDATA_s, '0);
    check("rst_pulses", {timeout_o, unmapped_o}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) xfer(vt[i]);
    bus.PSEL_s = 1'b0;
    bus.PENABLE_s = 1'b0;

    // Abort a stalled access to completer 4 with an async reset.
    set_model(vt[2]);
    hang[4] = 1'b1;
    @(posedge clk); #1;
    bus.PSEL_s = 1'b1; bus.PENABLE_s = 1'b0; bus.PWRITE_s = 1'b1;
    bus.PADDR_s = 32'h4000_4000; bus.PWDATA_s = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.PENABLE_s = 1'b1;
    repeat (2) @(posedge clk); #2;
    check("abort_pre_psel", bus.PSEL_m, 8'h10);
    check("abort_pre_penable", bus.PENABLE_m, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_psel", bus.PSEL_m, '0);
    check("abort_penable", bus.PENABLE_m, 1'b0);
    check("abort_paddr", bus.PADDR_m, '0);
    check("abort_pwdata", bus.PWDATA_m, '0);
    check("abort_pwrite", bus.PWRITE_m, 1'b0);
    check("abort_resp",
          {bus.PREADY_s, bus.PSLVERR_s, timeout_o, unmapped_o}, 4'b0);
    bus.PSEL_s = 1'b0;
    bus.PENABLE_s = 1'b0;
    hang[4] = 1'b0;
    @(posedge clk); #1;
    check("abort_hold_psel", bus.PSEL_m, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(mk("post_rst_s4", 0, 32'h4000_4000, 32'h0, 4'h0, 3'd0,
            4, 1, 1, 0, 32'h4444_0004, 0));
    bus.PSEL_s = 1'b0;
    bus.PENABLE_s = 1'b0;
    repeat (3) @(posedge clk); #1;

    check("total_tmo_pulses", tmo_cnt, 1);
    check("total_unm_pulses", unm_cnt, 3);
    check("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
